reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/wb_pkg.sv | 24 ++
 rtl/reg_write_arbiter_if.sv | 19 +
 rtl/wb_pair_fifo.sv | 47 ++++
 rtl/reg_write_arbiter.sv | 125 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths and writeback lane/pair types for the register write arbiter.
// A lane is one register write; a pair is what the dual-issue pipeline retires per cycle.
package wb_pkg;

    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic                     v;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    d;
    } wb_lane_t;

    typedef struct packed {
        wb_lane_t lane0;
        wb_lane_t lane1;
    } wb_pair_t;

    function automatic logic lane_hit(input wb_lane_t lane, input logic [ADDRESS_WIDTH-1:0] addr);
        return lane.v && (lane.rd == addr);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback-pair handshake between the dual-issue pipeline (master) and the arbiter (slave).
interface reg_write_arbiter_if;
    import wb_pkg::*;

    // in_valid/in_ready: a pair transfers on any posedge where both are high; in_ready
    // never depends on in_valid, and the master holds the pair stable while waiting.
    logic                     in_valid;
    logic                     in_ready;
    logic                     v0;
    logic [ADDRESS_WIDTH-1:0] rd0;
    logic [DATA_WIDTH-1:0]    d0;
    logic                     v1;
    logic [ADDRESS_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0]    d1;

    modport master (output in_valid, v0, rd0, d0, v1, rd1, d1, input in_ready);
    modport slave  (input in_valid, v0, rd0, d0, v1, rd1, d1, output in_ready);

endinterface

// File: rtl/wb_pair_fifo.sv
// Circular FIFO of writeback pairs; every slot is visible so the top can search pending writes.
module wb_pair_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  wb_pair_t      wr_data,
    input  logic          pop,
    output wb_pair_t      head,
    output logic [CW-1:0] count,
    output logic [PW-1:0] rd_ptr,
    output wb_pair_t      entries [DEPTH]
);

    wb_pair_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign head    = mem[rd_ptr];
    assign entries = mem;

endmodule

// File: rtl/reg_write_arbiter.sv
// Queues writeback pairs and maps each onto two register-file write ports with distinct,
// non-zero addresses; also forwards the youngest pending value for a lookup address.
module reg_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    reg_write_arbiter_if.slave       wb_in,
    input  logic                     wb_stall,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic                     WE6,
    output logic [ADDRESS_WIDTH-1:0] AD6,
    output logic [DATA_WIDTH-1:0]    WD6,
    input  logic [ADDRESS_WIDTH-1:0] q_addr,
    output logic                     q_hit,
    output logic [DATA_WIDTH-1:0]    q_data,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_pair_t      push_pair;
    wb_pair_t      head;
    wb_pair_t      entries [DEPTH];
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // x0 writes are dropped, and a same-register pair keeps only the younger lane.
    always_comb begin
        push_pair.lane0.v  = wb_in.v0 && (wb_in.rd0 != '0) && !(wb_in.v1 && (wb_in.rd1 == wb_in.rd0));
        push_pair.lane0.rd = wb_in.rd0;
        push_pair.lane0.d  = wb_in.d0;
        push_pair.lane1.v  = wb_in.v1 && (wb_in.rd1 != '0);
        push_pair.lane1.rd = wb_in.rd1;
        push_pair.lane1.d  = wb_in.d1;
    end

    assign wb_in.in_ready = (count < CW'(DEPTH));
    assign push           = wb_in.in_valid && wb_in.in_ready;
    assign pop            = (count != '0) && !wb_stall;

    wb_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_pair),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .rd_ptr  (rd_ptr),
        .entries (entries)
    );

    // Port 1 always carries the first surviving lane; port 2 only the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE3 <= 1'b0;
            AD3 <= '0;
            WD3 <= '0;
            WE6 <= 1'b0;
            AD6 <= '0;
            WD6 <= '0;
        end else if (pop) begin
            if (head.lane0.v) begin
                WE3 <= 1'b1;
                AD3 <= head.lane0.rd;
                WD3 <= head.lane0.d;
                WE6 <= head.lane1.v;
                AD6 <= head.lane1.rd;
                WD6 <= head.lane1.d;
            end else begin
                WE3 <= head.lane1.v;
                AD3 <= head.lane1.rd;
                WD3 <= head.lane1.d;
                WE6 <= 1'b0;
            end
        end else begin
            WE3 <= 1'b0;
            WE6 <= 1'b0;
        end
    end

    // Scan oldest to youngest so later matches override earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        q_hit  = 1'b0;
        q_data = '0;
        idx    = rd_ptr;
        if (WE3 && (AD3 == q_addr)) begin
            q_hit  = 1'b1;
            q_data = WD3;
        end
        if (WE6 && (AD6 == q_addr)) begin
            q_hit  = 1'b1;
            q_data = WD6;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (lane_hit(entries[idx].lane0, q_addr)) begin
                    q_hit  = 1'b1;
                    q_data = entries[idx].lane0.d;
                end
                if (lane_hit(entries[idx].lane1, q_addr)) begin
                    q_hit  = 1'b1;
                    q_data = entries[idx].lane1.d;
                end
            end
        end
        if (q_addr == '0) begin
            q_hit  = 1'b0;
            q_data = '0;
        end
    end

    assign empty = (count == '0) && !WE3 && !WE6;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_reg_write_arbiter;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
    } lane_m_t;

    typedef struct packed {
        lane_m_t l0;
        lane_m_t l1;
    } pair_m_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_stall;
    logic        WE3, WE6, q_hit, empty;
    logic [4:0]  AD3, AD6, q_addr;
    logic [31:0] WD3, WD6, q_data;

    int errors = 0;
    int checks = 0;

    pair_m_t     exp_q[$];
    logic        exp_we3, exp_we6;
    logic [4:0]  exp_ad3, exp_ad6;
    logic [31:0] exp_wd3, exp_wd6;

    reg_write_arbiter_if wb_in();

    reg_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_in    (wb_in),
        .wb_stall (wb_stall),
        .WE3      (WE3),
        .AD3      (AD3),
        .WD3      (WD3),
        .WE6      (WE6),
        .AD6      (AD6),
        .WD6      (WD6),
        .q_addr   (q_addr),
        .q_hit    (q_hit),
        .q_data   (q_data),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        wb_in.in_valid = 1'b0;
        wb_in.v0 = 1'b0; wb_in.rd0 = '0; wb_in.d0 = '0;
        wb_in.v1 = 1'b0; wb_in.rd1 = '0; wb_in.d1 = '0;
    endtask

    task automatic drive_pair(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
        wb_in.in_valid = 1'b1;
        wb_in.v0 = v0; wb_in.rd0 = rd0; wb_in.d0 = d0;
        wb_in.v1 = v1; wb_in.rd1 = rd1; wb_in.d1 = d1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_we3 = 1'b0;
        exp_we6 = 1'b0;
    endtask

    // One clock edge: the model applies the edge rules, then we settle 1 time unit past it.
    task automatic tick();
        logic    do_push, do_pop;
        pair_m_t p, h;
        lane_m_t w[$];
        do_push = wb_in.in_valid && (exp_q.size() < DEPTH);
        do_pop  = (exp_q.size() > 0) && !wb_stall;
        p.l0.v  = wb_in.v0 && (wb_in.rd0 != 0) && !(wb_in.v1 && wb_in.rd1 == wb_in.rd0);
        p.l0.rd = wb_in.rd0;
        p.l0.d  = wb_in.d0;
        p.l1.v  = wb_in.v1 && (wb_in.rd1 != 0);
        p.l1.rd = wb_in.rd1;
        p.l1.d  = wb_in.d1;
        @(posedge clk);
        exp_we3 = 1'b0;
        exp_we6 = 1'b0;
        if (do_pop) begin
            h = exp_q.pop_front();
            if (h.l0.v) w.push_back(h.l0);
            if (h.l1.v) w.push_back(h.l1);
            if (w.size() >= 1) begin
                exp_we3 = 1'b1; exp_ad3 = w[0].rd; exp_wd3 = w[0].d;
            end
            if (w.size() >= 2) begin
                exp_we6 = 1'b1; exp_ad6 = w[1].rd; exp_wd6 = w[1].d;
            end
        end
        if (do_push) exp_q.push_back(p);
        #1;
    endtask

    // Youngest pending write to addr, searching FIFO back to front, then port 2, then port 1.
    function automatic void model_lookup(input logic [4:0] a, output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (a == 0) return;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].l1.v && exp_q[i].l1.rd == a) begin hit = 1'b1; data = exp_q[i].l1.d; return; end
            if (exp_q[i].l0.v && exp_q[i].l0.rd == a) begin hit = 1'b1; data = exp_q[i].l0.d; return; end
        end
        if (exp_we6 && exp_ad6 == a) begin hit = 1'b1; data = exp_wd6; return; end
        if (exp_we3 && exp_ad3 == a) begin hit = 1'b1; data = exp_wd3; return; end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        wb_stall = 1'b0;
        q_addr   = 5'd5;
        rst_n    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got=%b exp=0", WE3); end
        checks++; if (WE6 !== 1'b0) begin errors++; $display("FAIL reset_we6 got=%b exp=0", WE6); end
        checks++; if ({AD3, AD6} !== 10'd0) begin errors++; $display("FAIL reset_ad got=%h/%h exp=0/0", AD3, AD6); end
        checks++; if ({WD3, WD6} !== 64'd0) begin errors++; $display("FAIL reset_wd got=%h/%h exp=0/0", WD3, WD6); end
        checks++; if (wb_in.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", wb_in.in_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL reset_q_hit got=%b exp=0", q_hit); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_write();
        drive_pair(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        tick();
        drive_idle();
        tick();
        checks++; if (WE3 !== 1'b1 || AD3 !== 5'd5 || WD3 !== 32'h11) begin
            errors++; $display("FAIL dual_port1 got=%b/%0d/%h exp=1/5/11", WE3, AD3, WD3); end
        checks++; if (WE6 !== 1'b1 || AD6 !== 5'd6 || WD6 !== 32'h22) begin
            errors++; $display("FAIL dual_port2 got=%b/%0d/%h exp=1/6/22", WE6, AD6, WD6); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL dual_empty_busy got=%b exp=0", empty); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL dual_empty_idle got=%b exp=1", empty); end
        checks++; if (WE3 !== 1'b0 || WE6 !== 1'b0) begin errors++; $display("FAIL dual_we_drop got=%b%b exp=00", WE3, WE6); end
    endtask

    task automatic test_same_rd();
        drive_pair(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        tick();
        drive_idle();
        tick();
        checks++; if (WE3 !== 1'b1 || AD3 !== 5'd7 || WD3 !== 32'hB) begin
            errors++; $display("FAIL same_rd_port1 got=%b/%0d/%h exp=1/7/b", WE3, AD3, WD3); end
        checks++; if (WE6 !== 1'b0) begin errors++; $display("FAIL same_rd_we6 got=%b exp=0", WE6); end
        tick();
    endtask

    task automatic test_x0_lane();
        drive_pair(1'b1, 5'd0, 32'h1, 1'b1, 5'd9, 32'h2);
        tick();
        drive_idle();
        tick();
        checks++; if (WE3 !== 1'b1 || AD3 !== 5'd9 || WD3 !== 32'h2) begin
            errors++; $display("FAIL x0_port1 got=%b/%0d/%h exp=1/9/2", WE3, AD3, WD3); end
        checks++; if (WE6 !== 1'b0) begin errors++; $display("FAIL x0_we6 got=%b exp=0", WE6); end
        tick();
    endtask

    task automatic test_stall_full();
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_pair(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(20 + i), 32'h200 + i);
            tick();
            checks++; if (WE3 !== 1'b0 || WE6 !== 1'b0) begin
                errors++; $display("FAIL stall_no_write i=%0d got=%b%b exp=00", i, WE3, WE6); end
        end
        checks++; if (wb_in.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", wb_in.in_ready); end
        drive_pair(1'b1, 5'd30, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        tick();
        drive_idle();
        wb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (WE3 !== 1'b1 || AD3 !== 5'(10 + i) || WD3 !== 32'h100 + i) begin
                errors++; $display("FAIL drain_port1 i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, WE3, AD3, WD3, 10 + i, 32'h100 + i); end
            checks++; if (WE6 !== 1'b1 || AD6 !== 5'(20 + i) || WD6 !== 32'h200 + i) begin
                errors++; $display("FAIL drain_port2 i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, WE6, AD6, WD6, 20 + i, 32'h200 + i); end
        end
        tick();
        checks++; if (WE3 !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL drain_done got=we3 %b empty %b exp=we3 0 empty 1", WE3, empty); end
    endtask

    task automatic test_lookup();
        wb_stall = 1'b1;
        drive_pair(1'b1, 5'd3, 32'h30, 1'b0, 5'd0, 32'h0);
        tick();
        drive_pair(1'b1, 5'd3, 32'h31, 1'b0, 5'd0, 32'h0);
        tick();
        drive_idle();
        q_addr = 5'd3;
        #1;
        checks++; if (q_hit !== 1'b1 || q_data !== 32'h31) begin
            errors++; $display("FAIL lookup_youngest got=%b/%h exp=1/31", q_hit, q_data); end
        q_addr = 5'd0;
        #1;
        checks++; if (q_hit !== 1'b0 || q_data !== 32'h0) begin
            errors++; $display("FAIL lookup_x0 got=%b/%h exp=0/0", q_hit, q_data); end
        wb_stall = 1'b0;
        tick();
        q_addr = 5'd3;
        #1;
        checks++; if (q_hit !== 1'b1 || q_data !== 32'h31) begin
            errors++; $display("FAIL lookup_fifo_over_port got=%b/%h exp=1/31", q_hit, q_data); end
        tick();
        tick();
        checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL lookup_drained got=%b exp=0", q_hit); end
        q_addr = 5'd0;
    endtask

    task automatic test_async_reset();
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_pair(1'b1, 5'(1 + i), 32'h40 + i, 1'b0, 5'd0, 32'h0);
            tick();
        end
        drive_idle();
        wb_stall = 1'b0;
        tick();
        checks++; if (WE3 !== 1'b1) begin errors++; $display("FAIL areset_pre_we3 got=%b exp=1", WE3); end
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++; if (WE3 !== 1'b0 || WE6 !== 1'b0) begin
            errors++; $display("FAIL areset_we got=%b%b exp=00", WE3, WE6); end
        checks++; if (empty !== 1'b1 || wb_in.in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_flags got=empty %b ready %b exp=1 1", empty, wb_in.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (WE3 !== 1'b0 || WE6 !== 1'b0 || empty !== 1'b1) begin
                errors++; $display("FAIL areset_after i=%0d got=we %b%b empty %b exp=we 00 empty 1", i, WE3, WE6, empty); end
        end
    endtask

    task automatic test_random();
        logic        m_hit;
        logic [31:0] m_data;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0)
                drive_pair(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
            else
                drive_idle();
            wb_stall = ($urandom_range(0, 9) < 3);
            tick();
            q_addr = 5'($urandom_range(0, 7));
            #1;
            model_lookup(q_addr, m_hit, m_data);
            checks++; if (WE3 !== exp_we3) begin errors++; $display("FAIL rand_we3 c=%0d got=%b exp=%b", c, WE3, exp_we3); end
            checks++; if (WE6 !== exp_we6) begin errors++; $display("FAIL rand_we6 c=%0d got=%b exp=%b", c, WE6, exp_we6); end
            if (exp_we3) begin
                checks++; if (AD3 !== exp_ad3 || WD3 !== exp_wd3) begin
                    errors++; $display("FAIL rand_port1 c=%0d got=%0d/%h exp=%0d/%h", c, AD3, WD3, exp_ad3, exp_wd3); end
            end
            if (exp_we6) begin
                checks++; if (AD6 !== exp_ad6 || WD6 !== exp_wd6) begin
                    errors++; $display("FAIL rand_port2 c=%0d got=%0d/%h exp=%0d/%h", c, AD6, WD6, exp_ad6, exp_wd6); end
            end
            checks++; if (wb_in.in_ready !== (exp_q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_in_ready c=%0d got=%b exp=%b", c, wb_in.in_ready, exp_q.size() < DEPTH); end
            checks++; if (empty !== (exp_q.size() == 0 && !exp_we3 && !exp_we6)) begin
                errors++; $display("FAIL rand_empty c=%0d got=%b", c, empty); end
            checks++; if (q_hit !== m_hit || q_data !== m_data) begin
                errors++; $display("FAIL rand_lookup c=%0d addr=%0d got=%b/%h exp=%b/%h", c, q_addr, q_hit, q_data, m_hit, m_data); end
        end
        drive_idle();
        wb_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_same_rd();
        test_x0_lane();
        test_stall_full();
        test_lookup();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
